// File: rtl/pool_window_reader.sv
// Read-side sequencer for the pooling tile register file: walks the 4x4 tile as four
// 2x2 windows, reduces each by max or average and hands the results out on valid/ready.
module pool_window_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  pool_mode_i,
    output logic [3:0]            add_rd0_o,
    output logic [3:0]            add_rd1_o,
    output logic [3:0]            add_rd2_o,
    output logic [3:0]            add_rd3_o,
    input  logic [DATA_WIDTH-1:0] rd_data0_i,
    input  logic [DATA_WIDTH-1:0] rd_data1_i,
    input  logic [DATA_WIDTH-1:0] rd_data2_i,
    input  logic [DATA_WIDTH-1:0] rd_data3_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            out_index_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    // state | meaning
    // IDLE  | waiting for start, addresses parked at 0
    // FETCH | addresses of window w driven, result captured at the edge
    // HOLD  | result presented on out_*, waiting for out_ready
    // DONE  | one-cycle done pulse after window 3 accepted
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [1:0]            win_q, win_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            index_q, index_d;

    logic [DATA_WIDTH-1:0] max01, max23, max_all, pooled;
    logic [DATA_WIDTH+1:0] sum;
    logic [3:0]            base;
    logic                  addr_en;

    always_comb begin
        max01   = (rd_data0_i > rd_data1_i) ? rd_data0_i : rd_data1_i;
        max23   = (rd_data2_i > rd_data3_i) ? rd_data2_i : rd_data3_i;
        max_all = (max01 > max23) ? max01 : max23;
        sum     = {2'b00, rd_data0_i} + {2'b00, rd_data1_i}
                + {2'b00, rd_data2_i} + {2'b00, rd_data3_i};
        pooled  = mode_q ? sum[DATA_WIDTH+1:2] : max_all;
    end

    // base = 8*row + 2*col of the window's top-left element
    assign base    = {win_q[1], 1'b0, win_q[0], 1'b0};
    assign addr_en = (state_q == S_FETCH) || (state_q == S_HOLD);

    assign add_rd0_o = addr_en ? base            : 4'd0;
    assign add_rd1_o = addr_en ? (base | 4'd1)   : 4'd0;
    assign add_rd2_o = addr_en ? (base | 4'd4)   : 4'd0;
    assign add_rd3_o = addr_en ? (base | 4'd5)   : 4'd0;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        mode_d  = mode_q;
        data_d  = data_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = pool_mode_i;
                    win_d   = 2'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_d  = pooled;
                index_d = win_q;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    if (win_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        win_d   = win_q + 2'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                win_d   = 2'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            win_q   <= 2'd0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            index_q <= 2'd0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            index_q <= index_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_index_o = index_q;
    assign out_valid_o = (state_q == S_HOLD);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_window_reader.sv
// Bench for pool_window_reader: register file model plus a window-level reference
// computed from tile row/column arithmetic.
module tb_pool_window_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pool_mode = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] add_rd0, add_rd1, add_rd2, add_rd3;
    logic [7:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       out_valid, busy, done;

    logic [7:0] rf [16];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rd_data0 = rf[add_rd0];
    assign rd_data1 = rf[add_rd1];
    assign rd_data2 = rf[add_rd2];
    assign rd_data3 = rf[add_rd3];

    pool_window_reader #(.DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pool_mode_i(pool_mode),
        .add_rd0_o(add_rd0), .add_rd1_o(add_rd1), .add_rd2_o(add_rd2), .add_rd3_o(add_rd3),
        .rd_data0_i(rd_data0), .rd_data1_i(rd_data1), .rd_data2_i(rd_data2), .rd_data3_i(rd_data3),
        .out_data_o(out_data), .out_index_o(out_index), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy), .done_o(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // element k (0..3, row-major inside the window) of window w
    function automatic int win_addr(input int w, input int k);
        return (2 * (w / 2) + k / 2) * 4 + 2 * (w % 2) + k % 2;
    endfunction

    function automatic int win_result(input int w, input logic mode);
        int mx = 0;
        int total = 0;
        for (int k = 0; k < 4; k++) begin
            int v = int'(rf[win_addr(w, k)]);
            total += v;
            if (v > mx) mx = v;
        end
        return mode ? total / 4 : mx;
    endfunction

    task automatic chk_addrs(input string tag, input int w, input bit parked);
        chk({tag, "_a0"}, 32'(add_rd0), parked ? 0 : win_addr(w, 0));
        chk({tag, "_a1"}, 32'(add_rd1), parked ? 0 : win_addr(w, 1));
        chk({tag, "_a2"}, 32'(add_rd2), parked ? 0 : win_addr(w, 2));
        chk({tag, "_a3"}, 32'(add_rd3), parked ? 0 : win_addr(w, 3));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_index"}, 32'(out_index), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk_addrs(tag, 0, 1'b1);
    endtask

    // Called at posedge+1; start is sampled at the next edge. phase: 0 fetch, 1 hold, 2 done.
    task automatic run_tile(input logic mode, input int stall_win, input int stall_len,
                            input bit rand_ready, input bit extra_start,
                            input int exp_done_cyc, input int abort_win);
        int  c = 1;
        int  w = 0;
        int  phase = 0;
        int  stall_left = stall_len;
        int  dones = 0;
        bit  finished = 0;
        bit  rdy;
        start = 1'b1;
        pool_mode = mode;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished) begin
            if (c > 200) begin
                chk("timeout", 32'(c), 200);
                finished = 1;
            end else if (abort_win >= 0 && phase == 1 && w == abort_win) begin
                rst = 1'b1;
                #1;
                chk_all_zero("rst_mid");
                @(posedge clk); #1;
                rst = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    chk("post_rst_valid", 32'(out_valid), 0);
                    chk("post_rst_done", 32'(done), 0);
                    chk("post_rst_busy", 32'(busy), 0);
                end
                finished = 1;
            end else begin
                chk("busy", 32'(busy), 1);
                chk("valid", 32'(out_valid), 32'(phase == 1));
                chk("done", 32'(done), 32'(phase == 2));
                chk_addrs("addr", w, phase == 2);
                if (phase == 1) begin
                    chk("index", 32'(out_index), 32'(w));
                    chk("data", 32'(out_data), 32'(win_result(w, mode)));
                end
                if (phase == 2) begin
                    dones++;
                    if (exp_done_cyc > 0) chk("done_cycle", 32'(c), 32'(exp_done_cyc));
                end
                rdy = 1'b1;
                if (phase == 1 && w == stall_win && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (rand_ready) begin
                    rdy = ($urandom_range(0, 2) != 0);
                end
                out_ready = rdy;
                if (extra_start && c == 3) begin
                    start = 1'b1;
                    pool_mode = ~mode;
                end
                @(posedge clk); #1;
                start = 1'b0;
                pool_mode = mode;
                c++;
                if (phase == 2) begin
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_done", 32'(done), 0);
                    chk("idle_valid", 32'(out_valid), 0);
                    chk_addrs("idle_addr", 0, 1'b1);
                    chk("done_count", 32'(dones), 1);
                    finished = 1;
                end else if (phase == 0) begin
                    phase = 1;
                end else if (rdy) begin
                    if (w == 3) phase = 2;
                    else begin
                        w++;
                        phase = 0;
                    end
                end
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'(i);
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("idle");

        run_tile(1'b0, -1, 0, 1'b0, 1'b0, 9, -1);
        run_tile(1'b1, -1, 0, 1'b0, 1'b0, 9, -1);

        for (int i = 0; i < 16; i++) rf[i] = 8'd255;
        run_tile(1'b1, -1, 0, 1'b0, 1'b0, 9, -1);
        run_tile(1'b0, -1, 0, 1'b0, 1'b0, 9, -1);

        for (int i = 0; i < 16; i++) rf[i] = 8'(i);
        run_tile(1'b0, 1, 5, 1'b0, 1'b0, 14, -1);
        run_tile(1'b0, -1, 0, 1'b0, 1'b1, 9, -1);
        run_tile(1'b1, -1, 0, 1'b0, 1'b1, 9, -1);

        run_tile(1'b0, -1, 0, 1'b0, 1'b0, 0, 2);
        run_tile(1'b0, -1, 0, 1'b0, 1'b0, 9, -1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
            run_tile(1'($urandom), -1, 0, 1'b1, 1'($urandom), 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
